// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encodings and legal parameter ranges.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'd0,
    ACT_CLIP   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_BYPASS = 2'd3
  } act_mode_e;

  localparam int DATA_W_MIN     = 4;
  localparam int DATA_W_MAX     = 32;
  localparam int LANES_MIN      = 1;
  localparam int LANES_MAX      = 16;
  localparam int LATENCY_MIN    = 1;
  localparam int LATENCY_MAX    = 8;
  localparam int LEAK_SHIFT_MIN = 1;

endpackage

// File: rtl/act_lane.sv
// Single-lane activation function, purely combinational (zero latency, no flow control).
// Result always fits DATA_W: every mode either passes x, zeroes it, clamps it or shrinks it.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_W-1:0] x,
  input  act_mode_e                mode,
  input  logic        [DATA_W-2:0] clip_max,
  output logic signed [DATA_W-1:0] y
);

  logic                     x_neg;
  logic signed [DATA_W-1:0] ceil_val;

  assign x_neg    = x[DATA_W-1];
  // Zero-extended ceiling is always non-negative, so a signed compare is safe.
  assign ceil_val = $signed({1'b0, clip_max});

  always_comb begin
    y = x;
    case (mode)
      ACT_RELU: begin
        if (x_neg) y = '0;
      end
      ACT_CLIP: begin
        if (x_neg)              y = '0;
        else if (x > ceil_val)  y = ceil_val;
      end
      ACT_LEAKY: begin
        // Arithmetic shift floors toward -inf, matching the leaky definition.
        if (x_neg) y = x >>> LEAK_SHIFT;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/act_unit_pipe.sv
// Multi-lane activation pipeline with a saturating negative-lane counter.
// LATENCY cycles accept-to-output; each stage loads when empty or draining, so a full pipe stalls in_ready.
module act_unit_pipe
  import act_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int LATENCY    = 3,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [1:0]                in_mode,
  input  logic [DATA_W-2:0]         clip_max,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      stat_clr,
  output logic [CNT_W-1:0]          stat_neg_cnt
);

  localparam int  BEAT_W = LANES * DATA_W;
  localparam int  NEG_W  = $clog2(LANES + 1);
  localparam int  SUM_W  = ((CNT_W > NEG_W) ? CNT_W : NEG_W) + 1;
  localparam bit  PARAMS_OK =
      (DATA_W >= DATA_W_MIN) && (DATA_W <= DATA_W_MAX) &&
      (LANES >= LANES_MIN) && (LANES <= LANES_MAX) &&
      (LATENCY >= LATENCY_MIN) && (LATENCY <= LATENCY_MAX) &&
      (LEAK_SHIFT >= LEAK_SHIFT_MIN) && (LEAK_SHIFT <= DATA_W - 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("act_unit_pipe: parameter out of legal range");
  end

  typedef logic [BEAT_W-1:0] beat_t;

  beat_t              stg_dat [LATENCY];
  logic               stg_vld [LATENCY];
  logic [LATENCY-1:0] load;
  beat_t              act_dat;
  act_mode_e          beat_mode;
  logic               init_done;
  logic               accept;
  logic [NEG_W-1:0]   neg_cnt;
  logic [SUM_W-1:0]   stat_sum;

  // Stage k can load if the output drains or any stage from k onward is empty;
  // the unrolled form avoids a combinational chain through the load vector.
  always_comb begin
    load = '0;
    for (int k = 0; k < LATENCY; k++) begin
      load[k] = out_ready;
      for (int j = k; j < LATENCY; j++) begin
        if (!stg_vld[j]) load[k] = 1'b1;
      end
    end
  end

  assign in_ready  = init_done && load[0];
  assign accept    = in_valid && in_ready;
  assign beat_mode = act_mode_e'(in_mode);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_W     (DATA_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_act_lane (
      .x        (in_data[i*DATA_W +: DATA_W]),
      .mode     (beat_mode),
      .clip_max (clip_max),
      .y        (act_dat[i*DATA_W +: DATA_W])
    );
  end

  // Held low through reset so in_ready rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld[0] <= 1'b0;
      stg_dat[0] <= '0;
    end else if (load[0]) begin
      stg_vld[0] <= accept;
      if (accept) stg_dat[0] <= act_dat;
    end
  end

  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_vld[k] <= 1'b0;
        stg_dat[k] <= '0;
      end else if (load[k]) begin
        stg_vld[k] <= stg_vld[k-1];
        if (stg_vld[k-1]) stg_dat[k] <= stg_dat[k-1];
      end
    end
  end

  assign out_valid = stg_vld[LATENCY-1];
  assign out_data  = stg_dat[LATENCY-1];

  always_comb begin
    neg_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_cnt = neg_cnt + NEG_W'(in_data[i*DATA_W + DATA_W - 1]);
    end
  end

  assign stat_sum = SUM_W'(stat_neg_cnt) + SUM_W'(neg_cnt);

  // Any carry above CNT_W means the true count no longer fits: pin at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_neg_cnt <= '0;
    end else if (stat_clr) begin
      stat_neg_cnt <= '0;
    end else if (accept) begin
      if (|stat_sum[SUM_W-1:CNT_W]) stat_neg_cnt <= {CNT_W{1'b1}};
      else                          stat_neg_cnt <= stat_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Bench for act_unit_pipe: vector table, scoreboard on every output, hand sequences for stall/saturation/reset.
module tb_act_unit_pipe;
  import act_pkg::*;

  localparam int DW  = 8;
  localparam int LN  = 4;
  localparam int LAT = 3;
  localparam int LS  = 3;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [LN*DW-1:0] in_data;
  logic [1:0]     in_mode;
  logic [DW-2:0]  clip_max;
  logic           out_valid;
  logic           out_ready;
  logic [LN*DW-1:0] out_data;
  logic           stat_clr;
  logic [CW-1:0]  stat_neg_cnt;

  always #5 clk = ~clk;

  act_unit_pipe #(
    .DATA_W(DW), .LANES(LN), .LATENCY(LAT), .LEAK_SHIFT(LS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .clip_max(clip_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stat_clr(stat_clr), .stat_neg_cnt(stat_neg_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  mode;
    logic [6:0]  cm;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference activation computed with integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m, input logic [6:0] cm);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < LN; i++) begin
      int x, y, c;
      logic [7:0] b;
      b = d[i*DW +: DW];
      x = int'($signed(b));
      c = int'(cm);
      case (m)
        2'd0:    y = (x < 0) ? 0 : x;
        2'd1:    y = (x < 0) ? 0 : ((x > c) ? c : x);
        2'd2:    y = (x < 0) ? -((-x + (1 << LS) - 1) / (1 << LS)) : x;
        default: y = x;
      endcase
      r[i*DW +: DW] = y[DW-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_stale: got beat %h expected no beat", out_data);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %h expected %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, in_mode, clip_max));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, gap, rdy_miss, acc_cnt, stable_err, out0, stale, expc;
    bit found, have, acc;
    logic [31:0] held;

    tbl[0] = '{32'h7F00FF80, 2'd0, 7'd0,   32'h7F000000};
    tbl[1] = '{32'h640605FD, 2'd1, 7'd6,   32'h06060500};
    tbl[2] = '{32'h0980F8FB, 2'd2, 7'd0,   32'h09F0FFFF};
    tbl[3] = '{32'h0980F8FB, 2'd3, 7'd0,   32'h0980F8FB};
    tbl[4] = '{32'h80407FFF, 2'd1, 7'd127, 32'h00407F00};
    tbl[5] = '{32'h8100F7FF, 2'd2, 7'd0,   32'hF000FEFF};
    tbl[6] = '{32'h0100FB05, 2'd1, 7'd0,   32'h00000000};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'd0;
    clip_max = '0; out_ready = 1'b1; stat_clr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stat", stat_neg_cnt, 0);
    #1 rst_n = 1'b1;
    #1 check("rel_in_ready_low", in_ready, 0);
    tick();
    check("rel_in_ready_high", in_ready, 1);

    // Single beats from the table: latency, data and first counter value.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = tbl[i].dat; in_mode = tbl[i].mode; clip_max = tbl[i].cm;
      tick();
      in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (out_valid) begin lat = c; break; end
      end
      check("tbl_latency", lat, LAT);
      check("tbl_data", out_data, tbl[i].exp);
      if (i == 0) check("stat_first", stat_neg_cnt, 2);
      tick();
    end

    // 20 back-to-back beats, mode cycling per beat.
    out0 = n_out; rdy_miss = 0; gap = 0; found = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          in_valid = 1'b1; in_data = $urandom; in_mode = 2'(i % 4);
          clip_max = 7'($urandom_range(0, 127));
          if (!in_ready) rdy_miss++;
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (out_valid) begin found = 1; break; end
        end
        for (int k = 1; k < 20; k++) begin
          @(negedge clk);
          if (!out_valid) gap++;
        end
        @(negedge clk);
        #1;
      end
    join
    check("b2b_found", found, 1);
    check("b2b_in_ready", rdy_miss, 0);
    check("b2b_gap", gap, 0);
    check("b2b_count", n_out - out0, 20);
    check("b2b_tail_valid", out_valid, 0);
    check("b2b_sb_empty", sb.size(), 0);
    tick();

    // Stall under continuous input: exactly LAT beats buffered, output frozen.
    out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom; in_mode = 2'($urandom_range(0, 3));
    clip_max = 7'($urandom_range(0, 127));
    out0 = n_out; acc_cnt = 0; stable_err = 0; have = 0; held = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) acc_cnt++;
      if (out_valid) begin
        if (!have) begin held = out_data; have = 1; end
        else if (out_data !== held) stable_err++;
      end
      tick();
      if (acc) begin
        in_data = $urandom; in_mode = 2'($urandom_range(0, 3));
        clip_max = 7'($urandom_range(0, 127));
      end
    end
    check("stall_buffered", acc_cnt, LAT);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_stable", stable_err, 0);
    check("stall_none_out", n_out - out0, 0);
    out_ready = 1'b1;
    #1 check("full_pass_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) break;
    end
    check("stall_delivered", n_out - out0, LAT + 1);
    check("stall_sb_empty", sb.size(), 0);
    tick();

    // Counter saturation and clear priority.
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_clr_idle", stat_neg_cnt, 0);
    expc = 0;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1; in_data = 32'h80F0FFC1; in_mode = 2'($urandom_range(0, 3));
      tick();
      in_valid = 1'b0;
      expc = (expc + 4 > 15) ? 15 : expc + 4;
      check("stat_sat", stat_neg_cnt, expc);
    end
    tick();
    check("stat_hold", stat_neg_cnt, 15);
    in_valid = 1'b1; stat_clr = 1'b1; in_data = 32'h80F0FFC1;
    tick();
    in_valid = 1'b0; stat_clr = 1'b0;
    check("stat_clr_accept", stat_neg_cnt, 0);
    in_valid = 1'b1; in_data = 32'h03FE01FF; in_mode = 2'd3;
    tick();
    in_valid = 1'b0;
    check("stat_mixed", stat_neg_cnt, 2);
    repeat (6) tick();

    // Reset with two beats in flight.
    out0 = n_out;
    in_valid = 1'b1; in_data = 32'h11223344; in_mode = 2'd3;
    tick();
    in_data = 32'h55667788;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_stat", stat_neg_cnt, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_rel_rdy_low", in_ready, 0);
    tick();
    check("rst_rel_rdy_high", in_ready, 1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    check("rst_no_delivery", n_out - out0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/act_unit_pipe.md
ACT_UNIT_PIPE -- requirements
Module: act_unit_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed element width, legal range 4..32.
REQ-002 SHALL have parameter LANES, default 4: elements processed per beat, legal range 1..16.
REQ-003 SHALL have parameter LATENCY, default 3: pipeline stages from accept to output, legal range 1..8.
REQ-004 SHALL have parameter LEAK_SHIFT, default 3: arithmetic right-shift used for leaky mode, legal range 1..DATA_W-1.
REQ-005 SHALL have parameter CNT_W, default 16: width of the statistics counter.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts the beat this cycle.
REQ-011 SHALL have port in_data, input, LANES*DATA_W bits: packed signed lanes, with lane i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port in_mode, input, 2 bits: activation select, sampled with the beat.
REQ-013 SHALL have port clip_max, input, DATA_W-1 bits: unsigned ceiling for clip mode, sampled with the beat.
REQ-014 SHALL have port out_valid, output, 1 bit: output beat present.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-016 SHALL have port out_data, output, LANES*DATA_W bits: packed signed results, same lane order as in_data.
REQ-017 SHALL have port stat_clr, input, 1 bit: synchronous clear of the statistics counter.
REQ-018 SHALL have port stat_neg_cnt, output, CNT_W bits: count of negative input lanes accepted.

Function
REQ-019 SHALL accept a beat when in_valid && in_ready, and transfer an output beat when out_valid && out_ready.
REQ-020 SHALL compute per lane, by mode:
- 0 ReLU: x<0 -> 0, else x.
- 1 clip: x<0 -> 0; x>clip_max -> clip_max; else x.
- 2 leaky: x<0 -> x>>>LEAK_SHIFT, rounding toward -inf; else x.
- 3 bypass: x.
REQ-021 SHALL keep every result within DATA_W bits without overflow; clip_max SHALL be zero-extended for comparison.
REQ-022 SHALL carry the mode and clip_max with each beat, so mode changes between consecutive beats take effect per beat with no flush.
REQ-023 SHALL be a LATENCY-deep chain of valid-tagged registers.
REQ-024 SHALL let stage k load when it is empty or stage k+1 (or the output, for the last stage) is unloading in the same cycle.
REQ-025 SHALL derive in_ready from stage 0 under the rule of REQ-024.
REQ-026 SHALL, with no stall, present an accepted beat on out_valid exactly LATENCY cycles after acceptance.
REQ-027 SHALL sustain throughput of 1 beat per cycle while out_ready=1.
REQ-028 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-029 SHALL lose and duplicate no beats, and SHALL preserve their order.
REQ-030 SHALL, when the pipeline is full and out_ready=0, hold in_ready=0.
REQ-031 SHALL, when the pipeline is full and out_ready=1, accept a simultaneous input beat (in_ready=1).
REQ-032 SHALL, on acceptance, add to stat_neg_cnt the number of lanes with x<0, saturating at 2^CNT_W-1 with no wrap.
REQ-033 SHALL give stat_clr priority over an increment in the same cycle, so the counter reads 0 next cycle.

Reset
REQ-034 SHALL, while rst_n=0, clear all stage valids, out_valid, out_data and stat_neg_cnt to 0, and hold in_ready=0.
REQ-035 SHALL discard in-flight beats when reset is asserted mid-operation, with no output afterward.
REQ-036 SHALL raise in_ready on the first clock edge after rst_n deasserts.

Structure
REQ-037 SHALL define in shared package act_pkg: the mode encodings (ACT_RELU=0, ACT_CLIP=1, ACT_LEAKY=2, ACT_BYPASS=3) and the parameter-range constants.
REQ-038 SHALL instantiate a combinational per-lane sub-module act_lane (x, mode, clip_max -> y) LANES times in stage 0.
REQ-039 SHALL realise the remaining stages as a generate-loop register chain.

Verification
REQ-040 SHALL cover: DATA_W=8, mode 0, lanes {-128,-1,0,127}, out_ready=1 -> out_data {0,0,0,127} exactly 3 cycles later; stat_neg_cnt=2.
REQ-041 SHALL cover: mode 1, clip_max=6, lanes {-3,5,6,100} -> {0,5,6,6}; mode 2, LEAK_SHIFT=3, lanes {-5,-8,-128,9} -> {-1,-1,-16,9}.
REQ-042 SHALL cover: 20 back-to-back beats with the mode cycling 0..3 per beat -> 20 outputs in order on consecutive cycles, each beat using its own mode.
REQ-043 SHALL cover: out_ready=0 for 10 cycles under continuous input -> exactly LATENCY beats buffered, in_ready=0, out_data stable; release -> all delivered, none lost.
REQ-044 SHALL cover: CNT_W=4, 5 beats of 4 negative lanes -> counter saturates at 15; stat_clr coincident with an accept -> 0.
REQ-045 SHALL cover: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale beat after release, in_ready=1 one cycle later.
